// File: rtl/pc_channel_buffer.sv
// Elastic first-word-fall-through FIFO carrying {pc, cc_id} tokens between
// ring engines; also reports occupancy as the downstream channel latency.
module pc_channel_buffer #(
    parameter int unsigned PC_WIDTH            = 8,
    parameter int unsigned CC_ID_BITS          = 1,
    parameter int unsigned DEPTH_BITS          = 3,
    parameter int unsigned LATENCY_COUNT_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                in_valid,
    input  logic [PC_WIDTH+CC_ID_BITS-1:0]      in_data,
    output logic                                in_ready,
    output logic                                out_valid,
    output logic [PC_WIDTH+CC_ID_BITS-1:0]      out_data,
    input  logic                                out_ready,
    output logic [LATENCY_COUNT_WIDTH-1:0]      out_latency,
    output logic [DEPTH_BITS:0]                 count,
    output logic                                full,
    output logic                                empty,
    output logic [DEPTH_BITS:0]                 max_count
);

    localparam int unsigned DATA_W = PC_WIDTH + CC_ID_BITS;
    localparam int unsigned CNT_W  = DEPTH_BITS + 1;
    localparam int unsigned DEPTH  = 1 << DEPTH_BITS;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]      next_count;
    logic                  push;
    logic                  pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Occupancy after this edge; flush wins over any handshake.
    always_comb begin
        next_count = count;
        if (flush) begin
            next_count = '0;
        end else begin
            case ({push, pop})
                2'b10:   next_count = count + CNT_W'(1);
                2'b01:   next_count = count - CNT_W'(1);
                default: next_count = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
                if (pop)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            end
            count <= next_count;
            if (next_count > max_count) max_count <= next_count;
        end
    end

    // Storage carries no reset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_data;
    end

    generate
        if (LATENCY_COUNT_WIDTH >= CNT_W) begin : g_latency_ext
            assign out_latency = LATENCY_COUNT_WIDTH'(count);
        end else begin : g_latency_sat
            localparam logic [CNT_W-1:0] SAT = CNT_W'((1 << LATENCY_COUNT_WIDTH) - 1);
            assign out_latency = (count > SAT) ? '1 : count[LATENCY_COUNT_WIDTH-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_pc_channel_buffer.sv
// Directed bench for pc_channel_buffer: fill/drain, streaming, full push+pop,
// flush, and asynchronous reset mid-stream.
module tb_pc_channel_buffer;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [8:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [8:0] out_data;
    logic       out_ready;
    logic [7:0] out_latency;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic [3:0] max_count;

    int n_checks = 0;
    int n_fail   = 0;

    pc_channel_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_latency(out_latency),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .max_count  (max_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check_eq("rst_count",   32'(count), 0);
        check_eq("rst_max",     32'(max_count), 0);
        check_eq("rst_empty",   32'(empty), 1);
        check_eq("rst_full",    32'(full), 0);
        check_eq("rst_in_rdy",  32'(in_ready), 1);
        check_eq("rst_out_vld", 32'(out_valid), 0);
        check_eq("rst_lat",     32'(out_latency), 0);
        check_eq("rst_data",    32'(out_data), 0);
        step();
        rst = 1'b1;

        // 1: three pushes, no pops
        in_valid = 1'b1; in_data = 9'h015; step();
        check_eq("t1_first_vld", 32'(out_valid), 1);
        in_data = 9'h02A; step();
        in_data = 9'h03F; step();
        in_valid = 1'b0;
        check_eq("t1_count", 32'(count), 3);
        check_eq("t1_vld",   32'(out_valid), 1);
        check_eq("t1_data",  32'(out_data), 32'h015);
        check_eq("t1_lat",   32'(out_latency), 3);
        check_eq("t1_max",   32'(max_count), 3);

        flush = 1'b1; step(); flush = 1'b0;
        check_eq("fl_count", 32'(count), 0);

        // 2: fill to full (pointers start mid-array after flush? no: flush resets to 0)
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 9'(32'h100 + i); step();
        end
        check_eq("t2_full",   32'(full), 1);
        check_eq("t2_in_rdy", 32'(in_ready), 0);
        check_eq("t2_count",  32'(count), 8);
        check_eq("t2_lat",    32'(out_latency), 8);
        in_data = 9'h1FF; step();
        check_eq("t2_ninth_ignored", 32'(count), 8);
        check_eq("t2_max", 32'(max_count), 8);
        check_eq("t2_head0", 32'(out_data), 32'h100);

        // 4: full with push and pop together -> pop only
        in_data = 9'h1EE; out_ready = 1'b1; step();
        in_valid = 1'b0;
        check_eq("t4_count",  32'(count), 7);
        check_eq("t4_in_rdy", 32'(in_ready), 1);

        // drain remaining in order
        for (int i = 1; i < 8; i++) begin
            check_eq("t2_drain", 32'(out_data), 32'h100 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        check_eq("t2_empty", 32'(empty), 1);
        check_eq("t2_out_vld", 32'(out_valid), 0);

        // 3: streaming, output = input delayed one cycle
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 9'(32'h40 + k);
            step();
            check_eq("t3_count", 32'(count), 1);
            check_eq("t3_data",  32'(out_data), 32'h40 + 32'(k));
        end
        in_valid = 1'b0; in_data = 'x; step();
        out_ready = 1'b0;
        check_eq("t3_drained", 32'(count), 0);

        // 6: asynchronous reset mid-stream at count=4
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 9'(32'h60 + i); step();
        end
        check_eq("t6_pre_count", 32'(count), 4);
        #3 rst = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("t6_out_vld", 32'(out_valid), 0);
        check_eq("t6_count",   32'(count), 0);
        check_eq("t6_max",     32'(max_count), 0);
        check_eq("t6_in_rdy",  32'(in_ready), 1);
        #1 rst = 1'b1;

        // 5: flush with concurrent push
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 9'(32'h50 + i); step();
        end
        check_eq("t5_pre_count", 32'(count), 5);
        flush = 1'b1; in_data = 9'h077; step();
        flush = 1'b0;
        check_eq("t5_count",   32'(count), 0);
        check_eq("t5_empty",   32'(empty), 1);
        check_eq("t5_out_vld", 32'(out_valid), 0);
        check_eq("t5_max",     32'(max_count), 5);
        in_data = 9'h0AA; step();
        in_valid = 1'b0; in_data = 'x;
        check_eq("t5_data",  32'(out_data), 32'h0AA);
        check_eq("t5_vld",   32'(out_valid), 1);
        step();
        check_eq("t5_hold",  32'(out_data), 32'h0AA);
        check_eq("t5_count1", 32'(count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_channel_buffer.md
Name: pc_channel_buffer

Overview:
- Elastic FIFO stage between the output PC channel of one vectorial engine and the input PC channel of the next engine in the ring.
- Stores {pc, cc_id} tokens and decouples the two engines with a valid/ready handshake.
- Drives the channel latency field that the downstream engine reads on input_pc_latency. The field is the saturating occupancy of this buffer.
- Provides full/empty status, a synchronous flush, and a max-occupancy performance counter.

Parameters:
- PC_WIDTH, 8, program-counter bits per token.
- CC_ID_BITS, 1, character-context id bits per token.
- DEPTH_BITS, 3, buffer depth is 2**DEPTH_BITS entries (minimum 1).
- LATENCY_COUNT_WIDTH, 8, width of the out_latency field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all stored tokens.
- in_valid  in  1  upstream token valid.
- in_data  in  PC_WIDTH+CC_ID_BITS  upstream token, {pc, cc_id}, with cc_id in the LSBs.
- in_ready  out  1  buffer can accept a token.
- out_valid  out  1  head token valid.
- out_data  out  PC_WIDTH+CC_ID_BITS  head token.
- out_ready  in  1  downstream accepts the head token.
- out_latency  out  LATENCY_COUNT_WIDTH  saturated occupancy.
- count  out  DEPTH_BITS+1  current occupancy, 0..2**DEPTH_BITS.
- full  out  1  count == 2**DEPTH_BITS.
- empty  out  1  count == 0.
- max_count  out  DEPTH_BITS+1  highest count reached since reset.

Behaviour:
- Reset (rst low, asynchronous): all pointers and counters clear, so count=0, max_count=0, empty=1, full=0, in_ready=1, out_valid=0, out_latency=0. out_data is 0 because memory contents are don't-care and out_data is masked to 0 while out_valid=0.
  - Release is synchronous to clk; the first accept can occur on the first rising edge with rst high.
- Storage: circular array of 2**DEPTH_BITS entries.
  - Write and read pointers are DEPTH_BITS wide and wrap modulo depth.
  - count is tracked separately, so full and empty are unambiguous when the pointers are equal.
- Push: in_valid && in_ready at a rising edge writes in_data at wr_ptr and increments wr_ptr.
- Pop: out_valid && out_ready at a rising edge increments rd_ptr.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- in_ready = !full. A full buffer does not accept a token even if a pop happens in the same cycle; there is no combinational ready path from out_ready.
- out_valid = !empty, and out_data = mem[rd_ptr] combinationally (first-word fall-through).
  - A token written into an empty buffer appears on out_valid the cycle after the push edge: 1-cycle latency.
  - There is no same-cycle bypass.
- Simultaneous push and pop:
  - With count=1: after the edge, the popped token is gone and the new token is at the head, count stays 1.
  - With full (count=depth): the pop occurs, the push is blocked (in_ready=0), and count becomes depth-1.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold.
- Wrap-around: pointers roll from depth-1 to 0 with no loss of ordering. Tokens leave strictly in arrival order.
- out_latency = count zero-extended, or saturated at 2**LATENCY_COUNT_WIDTH-1 if count exceeds that value. Combinational from count.
- flush: at a rising edge with flush=1, pointers and count clear.
  - A push or pop in the same cycle is discarded, so count is 0 next cycle.
  - max_count is NOT cleared by flush.
- max_count register: updates to next_count whenever next_count > max_count, and never decreases except on rst.
- in_data is sampled only on push. X on in_data while in_valid=0 must not propagate.

Test Plan:
1. Reset, then push tokens 0x015, 0x02A, 0x03F on consecutive cycles with out_ready=0 → count=3, out_valid=1, out_data=0x015, out_latency=3, max_count=3.
2. With DEPTH_BITS=3, push 8 tokens with out_ready=0 → full=1, in_ready=0. A 9th in_valid is ignored. Then drain with out_ready=1 → 8 tokens emerge in order, empty=1 after the 8th pop.
3. Streaming: in_valid=1 and out_ready=1 every cycle for 20 cycles, incrementing data → count steady at 1 after the first push, output sequence equals the input sequence delayed by 1 cycle, wr_ptr/rd_ptr wrap twice.
4. Full buffer with in_valid=1 and out_ready=1 in the same cycle → pop only, count 8→7, in_ready=1 next cycle.
5. Push 5 tokens, assert flush together with in_valid=1 → next cycle count=0, empty=1, out_valid=0, max_count=5. Then push 0x0AA → out_data=0x0AA after 1 cycle.
6. Assert rst low asynchronously mid-stream with count=4 (between clock edges) → outputs reach reset values immediately: out_valid=0, count=0, max_count=0, in_ready=1.
